bomb_time_setter: RTL

Front-panel time-entry controller for the bomb game. It lets the player dial a three-digit BCD start time with push buttons and arms or pauses the countdown. It drives the countdown block's `init_time[11:0]` bus and its one-cycle `SwitchOp` request, and consumes the countdown's `loose_control` flag to lock the panel once the timer expires.

---
 rtl/bomb_pkg.sv | 27 ++
 rtl/bomb_time_setter_btn_edge.sv | 19 +
 rtl/bomb_time_setter.sv | 90 +++++++++
 3 files changed

// File: rtl/bomb_pkg.sv
// bomb_pkg: shared state encoding, digit indices and BCD step helpers for the time setter
package bomb_pkg;

    typedef enum logic [1:0] {
        EDIT   = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [11:0] DEFAULT_TIME = 12'h060;
    localparam logic [11:0] MIN_TIME     = 12'h001;

    localparam logic [1:0] DIG_ONES  = 2'd0;
    localparam logic [1:0] DIG_TENS  = 2'd1;
    localparam logic [1:0] DIG_HUNDS = 2'd2;

    // Non-BCD digits behave as 9, so incrementing them wraps to 0
    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    // Non-BCD digits behave as 9, so decrementing them yields 8
    function automatic logic [3:0] bcd_dec(input logic [3:0] d);
        return (d == 4'd0) ? 4'd9 : (d > 4'd9) ? 4'd8 : d - 4'd1;
    endfunction

endpackage

// File: rtl/bomb_time_setter_btn_edge.sv
// btn_edge: one-cycle rising-edge detect on a debounced button level
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_press
);

    logic r_q;

    // History presets to 1 so a button held through reset is not seen as a press
    always_ff @(posedge clk) begin
        if (reset) r_q <= 1'b1;
        else       r_q <= i_btn;
    end

    assign o_press = i_btn & ~r_q;

endmodule

// File: rtl/bomb_time_setter.sv
// bomb_time_setter: front-panel BCD time entry with arm/pause control and expiry lock
module bomb_time_setter
    import bomb_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_next,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_arm,
    input  logic        loose_control,
    output logic [11:0] init_time,
    output logic        switch_op,
    output logic [1:0]  digit_sel,
    output logic        armed,
    output logic        locked,
    output logic        arm_err
);

    state_t      r_state, w_state_n;
    logic [11:0] r_time, w_time_n;
    logic [1:0]  r_sel, w_sel_n;
    logic        r_sw, w_sw_n;
    logic        r_err, w_err_n;
    logic        w_next, w_up, w_down, w_arm;
    logic        w_arm_ok;
    logic [3:0]  w_dig, w_new;

    btn_edge u_next (.clk(clk), .reset(reset), .i_btn(btn_next), .o_press(w_next));
    btn_edge u_up   (.clk(clk), .reset(reset), .i_btn(btn_up),   .o_press(w_up));
    btn_edge u_down (.clk(clk), .reset(reset), .i_btn(btn_down), .o_press(w_down));
    btn_edge u_arm  (.clk(clk), .reset(reset), .i_btn(btn_arm),  .o_press(w_arm));

    assign w_arm_ok = (r_time >= MIN_TIME);
    assign w_dig = (r_sel == DIG_HUNDS) ? r_time[11:8] :
                   (r_sel == DIG_TENS)  ? r_time[7:4]  : r_time[3:0];
    assign w_new = w_up ? bcd_inc(w_dig) : bcd_dec(w_dig);

    // Next state: expiry first, then arm > next > up/down; only the winner acts
    always_comb begin
        w_state_n = r_state;
        w_time_n  = r_time;
        w_sel_n   = r_sel;
        w_sw_n    = 1'b0;
        w_err_n   = 1'b0;
        if (r_state != LOCKED && loose_control) begin
            w_state_n = LOCKED;
        end else if (r_state == ARMED && w_arm) begin
            w_sw_n    = 1'b1;
            w_state_n = EDIT;
        end else if (r_state == EDIT) begin
            if (w_arm) begin
                w_sw_n    = w_arm_ok;
                w_err_n   = ~w_arm_ok;
                w_state_n = w_arm_ok ? ARMED : EDIT;
            end else if (w_next) begin
                w_sel_n = (r_sel == DIG_HUNDS) ? DIG_ONES : r_sel + 2'd1;
            end else if (w_up ^ w_down) begin
                w_time_n = {(r_sel == DIG_HUNDS) ? w_new : r_time[11:8],
                            (r_sel == DIG_TENS)  ? w_new : r_time[7:4],
                            (r_sel == DIG_ONES)  ? w_new : r_time[3:0]};
            end
        end
    end

    // State, edited time, digit select and registered pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= EDIT;
            r_time  <= DEFAULT_TIME;
            r_sel   <= DIG_ONES;
            r_sw    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_time  <= w_time_n;
            r_sel   <= w_sel_n;
            r_sw    <= w_sw_n;
            r_err   <= w_err_n;
        end
    end

    assign init_time = r_time;
    assign digit_sel = r_sel;
    assign switch_op = r_sw;
    assign arm_err   = r_err;
    assign armed     = (r_state == ARMED);
    assign locked    = (r_state == LOCKED);

endmodule
